// File: rtl/demux_rr_sched.sv
// Round-robin scheduler for the 1-to-4 demux select. It grants one channel
// at a time for a programmable burst and adds an optional guard gap between grants.
module demux_rr_sched #(
  parameter int BURST_W = 4,
  parameter int GAP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [BURST_W-1:0] burst_len,
  output logic [1:0]         sel,
  output logic               route_en,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic               busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  localparam logic [2:0] GCNT_INIT = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

  state_t             state, state_n;
  logic [1:0]         ptr, ptr_n, sel_n;
  logic [BURST_W-1:0] cnt, cnt_n;
  logic [2:0]         gcnt, gcnt_n;
  logic [3:0]         gnt_n, done_n;
  logic               route_n, busy_n;
  logic               found;
  logic [1:0]         winner, idx;

  // Scan req from ptr upward (mod 4); the first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = sel;
    gnt_n   = gnt;
    route_n = route_en;
    busy_n  = busy;
    done_n  = '0;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_GRANT;
          sel_n   = winner;
          gnt_n   = 4'b0001 << winner;
          route_n = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = (burst_len == '0) ? '0 : burst_len - BURST_W'(1);
        end
      end
      S_GRANT: begin
        if (cnt == '0 || !req[sel]) begin
          gnt_n   = '0;
          route_n = 1'b0;
          done_n  = 4'b0001 << sel;
          ptr_n   = sel + 2'd1;
          if (GAP > 0) begin
            state_n = S_GAP;
            gcnt_n  = GCNT_INIT;
            busy_n  = 1'b1;
          end else begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - BURST_W'(1);
        end
      end
      S_GAP: begin
        if (gcnt == '0) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
        end else begin
          gcnt_n = gcnt - 3'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sel      <= '0;
      gnt      <= '0;
      route_en <= 1'b0;
      busy     <= 1'b0;
      done     <= '0;
      ptr      <= '0;
      cnt      <= '0;
      gcnt     <= '0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      route_en <= route_n;
      busy     <= busy_n;
      done     <= done_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      gcnt     <= gcnt_n;
    end
  end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
Round-robin scheduler for the 1-to-4 clock/data demultiplexer. It shares the single routed source between four requesting channels. It drives the demux select, grants one channel at a time for a programmable burst of cycles, and inserts an optional guard gap between channel switches so that no glitch reaches a newly selected output. It sits directly in front of the demux select input.

Parameters:
BURST_W, 4, width of burst_len and of the internal burst counter.
GAP, 1, number of guard cycles (0..7) with route_en low after every grant ends.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
req  input  4  per-channel request; level, held high while the channel wants the demux.
burst_len  input  BURST_W  grant length in cycles; sampled on grant start; 0 is treated as 1.
sel  output  2  demux select; holds its last value when idle.
route_en  output  1  high only during GRANT; the demux output is valid only while high.
gnt  output  4  one-hot grant; bit i is high only while sel==i and route_en==1.
done  output  4  one-hot, one-cycle pulse in the first cycle after channel i's grant ends.
busy  output  1  high in GRANT or GAP.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, sel=0, route_en=0, gnt=0, done=0, busy=0, ptr=0, cnt=0. Reset asserted mid-grant aborts the grant immediately. No done pulse is produced for the aborted grant.
- State machine states: IDLE, GRANT, GAP. All outputs are registered.
- IDLE: the winner is chosen combinationally. It is the first set bit of req, scanning from ptr upward modulo 4. If req==0, stay in IDLE.
  - On the next edge: state=GRANT, sel=winner, gnt=onehot(winner), route_en=1, busy=1, cnt=max(burst_len,1)-1.
  - Latency: a req visible in IDLE at edge k gives gnt high from edge k+1.
- GRANT: cnt decrements by 1 each cycle. The grant ends when cnt==0, or early when req[sel] is sampled low.
  - The granted channel therefore holds gnt for exactly max(burst_len,1) cycles unless it drops its req first.
  - On the ending edge: gnt=0, route_en=0, done[sel]=1 for one cycle, ptr=(sel+1) mod 4.
  - Next state is GAP if GAP>0, otherwise IDLE. sel is unchanged.
- GAP: hold for exactly GAP cycles with route_en=0 and busy=1, then go to IDLE. Requests arriving in GAP are not lost; they are evaluated in IDLE.
- Minimum switch-over (last grant cycle to next grant cycle) is GAP+1 idle cycles.
- Fairness: a channel that was just served has the lowest priority on the next arbitration. Any continuously requesting channel is granted within 3 other grants.
- Changes to burst_len during GRANT are ignored. A req rising during GRANT on another channel has no effect until IDLE.
- A channel that drops and re-raises its req within its own grant still ends the grant at the drop.
- Invariants: gnt has at most one bit set. route_en == |gnt. done and gnt are never high for the same channel in the same cycle.

Test Plan:
1. Reset then req=4'b0010, burst_len=3, GAP=1 -> gnt=0010, sel=1, route_en=1 for exactly 3 cycles; done=0010 for 1 cycle; route_en low for 1 GAP cycle and 1 IDLE cycle; then gnt=0010 again if req is still high.
2. req=4'b1111 held, burst_len=2 -> grant order ch0, ch1, ch2, ch3, ch0. Each grant lasts 2 cycles. sel sequence is 0,1,2,3,0.
3. req=4'b0101, ch0 granted with burst_len=8; drop req[0] after 2 grant cycles -> grant ends after cycle 2; done=0001; next grant goes to ch2, not ch0.
4. burst_len=0 with req=4'b1000 -> 1-cycle grant, sel=3, done=1000 on the following cycle.
5. Assert rst in the 3rd cycle of a 6-cycle grant -> the next cycle has gnt=0, route_en=0, sel=0, done=0, busy=0. Arbitration restarts from ch0.
6. Build with GAP=0, req=4'b0011, burst_len=1 -> alternating 1-cycle grants ch0, ch1 with exactly one route_en-low cycle between them. gnt is never multi-hot.
